// File: rtl/fft8_pkg.sv
// Shared constants, complex payload type and arithmetic helpers for the 8-point FFT.
// FFT8_ROUND_EN selects round-half-away-from-zero twiddle products (default: truncate toward zero).
package fft8_pkg;

    localparam int unsigned W          = 32;
    localparam int unsigned TW_Q       = 8;
    localparam int unsigned TW_C       = 181;
    localparam int unsigned IW         = W + 3;
    localparam int unsigned PW         = IW + TW_Q;
    localparam int unsigned ROUND_HALF = 1 << (TW_Q - 1);

    localparam logic [IW-1:0] MAG_MAX = IW'({(W-1){1'b1}});

    typedef struct packed {
        logic signed [IW-1:0] re;
        logic signed [IW-1:0] im;
    } cplx_t;

    // Sign-magnitude to two's complement; negative zero collapses to 0.
    function automatic logic signed [IW-1:0] sm2tc(input logic [W-1:0] x);
        logic signed [IW-1:0] m;
        m = signed'(IW'(x[W-2:0]));
        return x[W-1] ? -m : m;
    endfunction

    // Two's complement to sign-magnitude with magnitude saturation and positive zero.
    function automatic logic [W-1:0] tc2sm_sat(input logic signed [IW-1:0] v);
        logic          neg;
        logic [IW-1:0] mag;
        neg = v[IW-1];
        mag = neg ? unsigned'(-v) : unsigned'(v);
        if (mag > MAG_MAX) begin
            return {neg, {(W-1){1'b1}}};
        end
        return {neg && (mag != '0), mag[W-2:0]};
    endfunction

    // Scale by TW_C/2^TW_Q on the magnitude so the result is symmetric about zero.
    function automatic logic signed [IW-1:0] twid_mul(input logic signed [IW-1:0] v);
        logic                 neg;
        logic [PW-1:0]        prod;
        logic signed [IW-1:0] r;
        neg  = v[IW-1];
        prod = PW'(neg ? unsigned'(-v) : unsigned'(v)) * PW'(TW_C);
`ifdef FFT8_ROUND_EN
        prod = prod + PW'(ROUND_HALF);
`else
        prod = prod + PW'(0);
`endif
        r = signed'(prod[PW-1:TW_Q]);
        return neg ? -r : r;
    endfunction

    // (a+jb)*(-j) = b - ja
    function automatic cplx_t mul_mj(input cplx_t c);
        cplx_t r;
        r.re = c.im;
        r.im = -c.re;
        return r;
    endfunction

    // (a+jb)*(1-j)/sqrt2
    function automatic cplx_t mul_w1(input cplx_t c);
        cplx_t r;
        r.re = twid_mul(c.re + c.im);
        r.im = twid_mul(c.im - c.re);
        return r;
    endfunction

    // (a+jb)*(-1-j)/sqrt2
    function automatic cplx_t mul_w3(input cplx_t c);
        cplx_t r;
        r.re = twid_mul(c.im - c.re);
        r.im = twid_mul(-c.re - c.im);
        return r;
    endfunction

endpackage

// File: rtl/fft8_bfly.sv
// Combinational radix-2 complex butterfly: (p, q) -> (p+q, p-q).
module fft8_bfly
    import fft8_pkg::*;
(
    input  cplx_t p_i,
    input  cplx_t q_i,
    output cplx_t sum_c_o,
    output cplx_t dif_c_o
);

    assign sum_c_o.re = p_i.re + q_i.re;
    assign sum_c_o.im = p_i.im + q_i.im;
    assign dif_c_o.re = p_i.re - q_i.re;
    assign dif_c_o.im = p_i.im - q_i.im;

endmodule

// File: rtl/fft8_core.sv
// Three-stage pipelined 8-point radix-2 DIT FFT on sign-magnitude real samples.
// Build with FFT8_ROUND_EN for rounded twiddle products; latency and ports are unchanged.
module fft8_core
    import fft8_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    input  logic [W-1:0] a3,
    input  logic [W-1:0] a4,
    input  logic [W-1:0] a5,
    input  logic [W-1:0] a6,
    input  logic [W-1:0] a7,
    output logic         out_valid,
    output logic [W-1:0] xr0,
    output logic [W-1:0] xr1,
    output logic [W-1:0] xr2,
    output logic [W-1:0] xr3,
    output logic [W-1:0] xr4,
    output logic [W-1:0] xr5,
    output logic [W-1:0] xr6,
    output logic [W-1:0] xr7,
    output logic [W-1:0] xi0,
    output logic [W-1:0] xi1,
    output logic [W-1:0] xi2,
    output logic [W-1:0] xi3,
    output logic [W-1:0] xi4,
    output logic [W-1:0] xi5,
    output logic [W-1:0] xi6,
    output logic [W-1:0] xi7
);

    logic [7:0][W-1:0] a_c;
    cplx_t [7:0]       x_c;
    cplx_t [7:0]       s1_d, s1_q;
    cplx_t [7:0]       s2_in_c, s2_d, s2_q;
    cplx_t [7:0]       s3_in_c, s3_d;
    logic  [7:0][W-1:0] xr_d, xr_q, xi_d, xi_q;
    logic              v1_q, v2_q, out_valid_q;

    assign a_c = {a7, a6, a5, a4, a3, a2, a1, a0};

    always_comb begin
        x_c = '0;
        for (int i = 0; i < 8; i++) begin
            x_c[i].re = sm2tc(a_c[i]);
        end
    end

    // Stage 1: pairs (x0,x4),(x2,x6),(x1,x5),(x3,x7) land in s1[2g], s1[2g+1].
    for (genvar g = 0; g < 4; g++) begin : g_st1
        localparam int unsigned P = ((g & 1) << 1) | (g >> 1);
        fft8_bfly u_bfly (
            .p_i     (x_c[P]),
            .q_i     (x_c[P+4]),
            .sum_c_o (s1_d[2*g]),
            .dif_c_o (s1_d[2*g+1])
        );
    end

    always_comb begin
        s2_in_c    = s1_q;
        s2_in_c[3] = mul_mj(s1_q[3]);
        s2_in_c[7] = mul_mj(s1_q[7]);
    end

    // Stage 2: 4-point combine within the even half [0..3] and odd half [4..7].
    for (genvar g = 0; g < 4; g++) begin : g_st2
        localparam int unsigned P = (g >> 1) * 4 + (g & 1);
        fft8_bfly u_bfly (
            .p_i     (s2_in_c[P]),
            .q_i     (s2_in_c[P+2]),
            .sum_c_o (s2_d[P]),
            .dif_c_o (s2_d[P+2])
        );
    end

    always_comb begin
        s3_in_c    = s2_q;
        s3_in_c[5] = mul_w1(s2_q[5]);
        s3_in_c[6] = mul_mj(s2_q[6]);
        s3_in_c[7] = mul_w3(s2_q[7]);
    end

    // Stage 3: X[k] = E[k] + W8^k O[k], X[k+4] = E[k] - W8^k O[k].
    for (genvar g = 0; g < 4; g++) begin : g_st3
        fft8_bfly u_bfly (
            .p_i     (s3_in_c[g]),
            .q_i     (s3_in_c[g+4]),
            .sum_c_o (s3_d[g]),
            .dif_c_o (s3_d[g+4])
        );
    end

    always_comb begin
        xr_d = '0;
        xi_d = '0;
        for (int k = 0; k < 8; k++) begin
            xr_d[k] = tc2sm_sat(s3_d[k].re);
            xi_d[k] = tc2sm_sat(s3_d[k].im);
        end
    end

    // Data registers only load with a valid word so the output holds between vectors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            xr_q        <= '0;
            xi_q        <= '0;
        end else begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (in_valid) begin
                s1_q <= s1_d;
            end
            if (v1_q) begin
                s2_q <= s2_d;
            end
            if (v2_q) begin
                xr_q <= xr_d;
                xi_q <= xi_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign xr0 = xr_q[0];
    assign xr1 = xr_q[1];
    assign xr2 = xr_q[2];
    assign xr3 = xr_q[3];
    assign xr4 = xr_q[4];
    assign xr5 = xr_q[5];
    assign xr6 = xr_q[6];
    assign xr7 = xr_q[7];
    assign xi0 = xi_q[0];
    assign xi1 = xi_q[1];
    assign xi2 = xi_q[2];
    assign xi3 = xi_q[3];
    assign xi4 = xi_q[4];
    assign xi5 = xi_q[5];
    assign xi6 = xi_q[6];
    assign xi7 = xi_q[7];

endmodule

// File: tb/tb_fft8_core.sv
// Directed self-checking bench for fft8_core with hand-computed spectra.
module tb_fft8_core;

    typedef logic [31:0] vec_t [8];
    typedef int          ivec_t [8];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a [8];
    logic        out_valid;
    logic [31:0] xr [8];
    logic [31:0] xi [8];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fft8_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a0        (a[0]), .a1 (a[1]), .a2 (a[2]), .a3 (a[3]),
        .a4        (a[4]), .a5 (a[5]), .a6 (a[6]), .a7 (a[7]),
        .out_valid (out_valid),
        .xr0       (xr[0]), .xr1 (xr[1]), .xr2 (xr[2]), .xr3 (xr[3]),
        .xr4       (xr[4]), .xr5 (xr[5]), .xr6 (xr[6]), .xr7 (xr[7]),
        .xi0       (xi[0]), .xi1 (xi[1]), .xi2 (xi[2]), .xi3 (xi[3]),
        .xi4       (xi[4]), .xi5 (xi[5]), .xi6 (xi[6]), .xi7 (xi[7])
    );

    function automatic logic [31:0] sm(input int v);
        return (v < 0) ? {1'b1, 31'(-v)} : {1'b0, 31'(v)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_spec(input string tag, input ivec_t er, input ivec_t ei);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s xr%0d", tag, k), xr[k], sm(er[k]));
            chk($sformatf("%s xi%0d", tag, k), xi[k], sm(ei[k]));
        end
    endtask

    task automatic drive(input logic v, input vec_t d);
        in_valid = v;
        for (int i = 0; i < 8; i++) a[i] = d[i];
    endtask

    // Present one vector for a single cycle; output appears in the third cycle after it.
    task automatic run_one(input string tag, input vec_t d);
        @(negedge clk);
        drive(1'b1, d);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, " out_valid early"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    endtask

    vec_t  zero_v, v1, vimp, vneg, vmax, vk;
    ivec_t er, ei;

    initial begin
        for (int i = 0; i < 8; i++) zero_v[i] = 32'h0;
        drive(1'b0, zero_v);

        // Reset state
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst xr0", xr[0], 32'd0);
        chk("rst xi5", xi[5], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Mixed real vector
        v1 = '{32'd120, 32'd130, 32'd0, 32'd110, 32'd0, 32'd150, 32'd200, 32'd0};
`ifdef FFT8_ROUND_EN
        er = '{710, 28, -80, 212, -70, 212, -80, 28};
        ei = '{0, 136, -170, -264, 0, 264, 170, -136};
`else
        er = '{710, 29, -80, 211, -70, 211, -80, 29};
        ei = '{0, 137, -170, -263, 0, 263, 170, -137};
`endif
        run_one("mixed", v1);
        chk_spec("mixed", er, ei);
        chk("neg80 encoding", xr[2], 32'h8000_0050);
        @(negedge clk);
        chk("hold out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold xr0", xr[0], sm(710));
        chk("hold xi3", xi[3], sm(ei[3]));

        // Impulse; the other samples are negative zero
        vimp = '{32'd1000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        er = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
        ei = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_one("impulse", vimp);
        chk_spec("impulse", er, ei);

        // Negative impulse
        vneg = '{32'h8000_0005, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        er = '{-5, -5, -5, -5, -5, -5, -5, -5};
        run_one("negimp", vneg);
        chk_spec("negimp", er, ei);

        // Full-scale DC saturates bin 0
        for (int i = 0; i < 8; i++) vmax[i] = 32'h7FFF_FFFF;
        er = '{32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0};
        run_one("satdc", vmax);
        chk_spec("satdc", er, ei);

        // Four back-to-back vectors: a0=100(k+1), a4=10(k+1) -> even bins 110(k+1), odd 90(k+1)
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 6) begin
                chk($sformatf("b2b%0d out_valid", c - 3), {31'd0, out_valid}, 32'd1);
                chk($sformatf("b2b%0d xr0", c - 3), xr[0], sm(110 * (c - 2)));
                chk($sformatf("b2b%0d xr1", c - 3), xr[1], sm(90 * (c - 2)));
                chk($sformatf("b2b%0d xi1", c - 3), xi[1], 32'd0);
            end else begin
                chk($sformatf("b2b idle%0d out_valid", c), {31'd0, out_valid}, 32'd0);
            end
            vk = zero_v;
            if (c < 4) begin
                vk[0] = 32'(100 * (c + 1));
                vk[4] = 32'(10 * (c + 1));
            end
            drive(c < 4, vk);
        end

        // Asynchronous reset with vectors in flight
        @(negedge clk);
        drive(1'b1, v1);
        @(negedge clk);
        drive(1'b1, vimp);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst xr0", xr[0], 32'd0);
        chk("arst xr1", xr[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post-rst%0d out_valid", c), {31'd0, out_valid}, 32'd0);
        end
        chk("post-rst xr0", xr[0], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
